// File: rtl/tt_scan_pkg.sv
// Shared constants for the truth-table scanner: FSM encoding, default
// input width and the lab function's reference table.
package tt_scan_pkg;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Default input vector width of the function under test
    localparam int TT_WIDTH_DEF = 4;

    // Lab function SOP(0,1,3,4,8,9,15): bit n = f(n)
    localparam logic [15:0] TT_LAB_EXPECTED = 16'h831B;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// settle_timer: loadable down-counter that gates each sample step of the
// scanner. o_zero is high when the driven index has settled long enough.
// With CYCLES == 0 the counter disappears and o_zero is tied high.
module settle_timer #(
    parameter int CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    generate
        if (CYCLES == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_load, i_en};
            assign o_zero   = 1'b1;
        end else begin : g_cnt
            localparam int CW = $clog2(CYCLES + 1);
            logic [CW-1:0] r_cnt;

            // Reload on request, otherwise count down to zero while enabled
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (i_load) begin
                    r_cnt <= CW'(CYCLES);
                end else if (i_en && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign o_zero = (r_cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives 0..2^WIDTH-1 into a combinational function,
// samples its single-bit output per index and builds the truth table plus
// a count of true minterms.
// Optional self-check against a reference table: define TT_SCAN_CHECK_EN
// to add the EXPECTED parameter and the match / first_bad outputs.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int WIDTH         = TT_WIDTH_DEF,
    parameter int SETTLE_CYCLES = 0
`ifdef TT_SCAN_CHECK_EN
    ,
    parameter logic [2**WIDTH-1:0] EXPECTED = (2**WIDTH)'(TT_LAB_EXPECTED)
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 f_in,
    output logic [WIDTH-1:0]     i_out,
    output logic [2**WIDTH-1:0]  table_out,
    output logic [WIDTH:0]       ones_cnt,
    output logic                 busy,
`ifdef TT_SCAN_CHECK_EN
    output logic                 match,
    output logic [WIDTH-1:0]     first_bad,
`endif
    output logic                 done
);

    localparam int               DEPTH = 2**WIDTH;
    localparam logic [WIDTH-1:0] LAST  = '1;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_idx;
    logic [DEPTH-1:0] r_table;
    logic [WIDTH:0]   r_ones;

    logic             w_zero;
    logic             w_sample;
    logic             w_last;
    logic             w_start;
    logic             w_load;
    logic [DEPTH-1:0] w_table_nxt;

    assign w_start  = (r_state == ST_IDLE) && start;
    assign w_sample = (r_state == ST_SCAN) && w_zero;
    assign w_last   = (r_idx == LAST);
    // Reload the settle delay whenever a new index starts being driven
    assign w_load   = w_start || (w_sample && !w_last);

    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (r_state == ST_SCAN),
        .o_zero (w_zero)
    );

    // Table with the current sample merged in; used for the update and the check
    always_comb begin
        w_table_nxt        = r_table;
        w_table_nxt[r_idx] = f_in;
    end

    // Scan FSM, index register, table and minterm counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_table <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SCAN;
                        r_idx   <= '0;
                        r_table <= '0;
                        r_ones  <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_zero) begin
                        r_table <= w_table_nxt;
                        r_ones  <= r_ones + (WIDTH+1)'(f_in);
                        // Terminal index checked before incrementing: no wrap
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_out     = r_idx;
    assign table_out = r_table;
    assign ones_cnt  = r_ones;
    assign busy      = (r_state == ST_SCAN);
    assign done      = (r_state == ST_DONE);

`ifdef TT_SCAN_CHECK_EN
    logic [DEPTH-1:0] w_diff;
    logic [WIDTH-1:0] w_first_bad;
    logic             r_match;
    logic [WIDTH-1:0] r_first_bad;

    // Lowest differing index; scanning high-to-low leaves the lowest hit
    always_comb begin
        w_diff      = w_table_nxt ^ EXPECTED;
        w_first_bad = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_diff[i]) w_first_bad = WIDTH'(i);
        end
    end

    // Verdict captured on the final sample so it is valid together with done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match     <= 1'b0;
            r_first_bad <= '0;
        end else if (w_start) begin
            r_match     <= 1'b0;
            r_first_bad <= '0;
        end else if (w_sample && w_last) begin
            r_match     <= (w_diff == '0);
            r_first_bad <= w_first_bad;
        end
    end

    assign match     = r_match;
    assign first_bad = r_first_bad;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: stimulus pushes the expected scan result, per-DUT
// monitors pop and compare whenever done is seen.
// DUT0: WIDTH=4, SETTLE_CYCLES=0. DUT1: WIDTH=4, SETTLE_CYCLES=2.
module tb_truth_table_scanner;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  ones;
        int          cyc;
        logic        m;
        logic [3:0]  fb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] func0 = 16'h0, func1 = 16'h0;
    logic        f_in0, f_in1;
    logic [3:0]  i_out0, i_out1;
    logic [15:0] tbl0, tbl1;
    logic [4:0]  ones0, ones1;
    logic        busy0, busy1, done0, done1;
`ifdef TT_SCAN_CHECK_EN
    logic        match0, match1;
    logic [3:0]  fb0, fb1;
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function under test: pure lookup on the driven index
    assign f_in0 = func0[i_out0];
    assign f_in1 = func1[i_out1];

    truth_table_scanner #(.WIDTH(4), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f_in0),
        .i_out(i_out0), .table_out(tbl0), .ones_cnt(ones0), .busy(busy0),
`ifdef TT_SCAN_CHECK_EN
        .match(match0), .first_bad(fb0),
`endif
        .done(done0)
    );

    truth_table_scanner #(.WIDTH(4), .SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f_in1),
        .i_out(i_out1), .table_out(tbl1), .ones_cnt(ones1), .busy(busy1),
`ifdef TT_SCAN_CHECK_EN
        .match(match1), .first_bad(fb1),
`endif
        .done(done1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor DUT0
    always @(negedge clk) begin
        if (rst_n && done0) begin
            if (q0.size() == 0) begin
                fail_now("dut0 unexpected done");
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0 table", tbl0, e.tbl);
                chk("dut0 ones", ones0, e.ones);
                chk("dut0 done cycle", cyc, e.cyc);
                chk("dut0 i_out after done", i_out0, 0);
                chk("dut0 busy in done", busy0, 0);
`ifdef TT_SCAN_CHECK_EN
                chk("dut0 match", match0, e.m);
                chk("dut0 first_bad", fb0, e.fb);
`endif
            end
        end
    end

    // Monitor DUT1
    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                fail_now("dut1 unexpected done");
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1 table", tbl1, e.tbl);
                chk("dut1 ones", ones1, e.ones);
                chk("dut1 done cycle", cyc, e.cyc);
                chk("dut1 i_out after done", i_out1, 0);
`ifdef TT_SCAN_CHECK_EN
                chk("dut1 match", match1, e.m);
                chk("dut1 first_bad", fb1, e.fb);
`endif
            end
        end
    end

    // Pulse start on DUT0 for one edge and queue the expected result
    task automatic scan0(input logic [15:0] f, input logic [15:0] t, input logic [4:0] o,
                         input logic m, input logic [3:0] fb);
        exp_t e;
        @(negedge clk);
        func0 = f;
        e.tbl = t; e.ones = o; e.cyc = cyc + 1 + 16; e.m = m; e.fb = fb;
        q0.push_back(e);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now({name, " timeout waiting for done"});
        @(negedge clk);
    endtask

    task automatic wait_idx0(input logic [3:0] v);
        int n = 0;
        while (i_out0 != v && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("dut0 timeout waiting for index");
    endtask

    initial begin
        exp_t e;
        int   k;
        logic hold_ok;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst i_out0", i_out0, 0);
        chk("rst table0", tbl0, 0);
        chk("rst ones0", ones0, 0);
        chk("rst busy0", busy0, 0);
        chk("rst done0", done0, 0);
        chk("rst i_out1", i_out1, 0);
        chk("rst busy1", busy1, 0);
`ifdef TT_SCAN_CHECK_EN
        chk("rst match0", match0, 0);
        chk("rst first_bad0", fb0, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lab function, all-ones, all-zeros
        scan0(16'h831B, 16'h831B, 5'd7, 1'b1, 4'd0);
        drain("sop");
        scan0(16'hFFFF, 16'hFFFF, 5'd16, 1'b0, 4'd2);
        drain("ones");
        scan0(16'h0000, 16'h0000, 5'd0, 1'b0, 4'd0);
        drain("zeros");
        chk("idle keeps ones", ones0, 0);

        // Settle of 2: each index held 3 cycles, done 48 edges after start
        @(negedge clk);
        func1 = 16'h831B;
        k = cyc + 1;
        e.tbl = 16'h831B; e.ones = 5'd7; e.cyc = k + 48; e.m = 1'b1; e.fb = 4'd0;
        q1.push_back(e);
        start1 = 1'b1;
        hold_ok = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int j = 0; j < 48; j++) begin
            if (i_out1 != 4'((cyc - k) / 3)) hold_ok = 1'b0;
            if (j != 47) @(negedge clk);
        end
        chk("dut1 index hold pattern", hold_ok, 1);
        drain("settle");

        // start re-pulsed mid-scan is ignored
        scan0(16'h831B, 16'h831B, 5'd7, 1'b1, 4'd0);
        wait_idx0(4'd5);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain("restart ignored");

        // start held high: back-to-back scans with DONE + IDLE in between
        @(negedge clk);
        k = cyc + 1;
        e.tbl = 16'h831B; e.ones = 5'd7; e.m = 1'b1; e.fb = 4'd0;
        e.cyc = k + 16; q0.push_back(e);
        e.cyc = k + 34; q0.push_back(e);
        start0 = 1'b1;
        while (cyc < k + 18) @(negedge clk);
        start0 = 1'b0;
        chk("held start busy", busy0, 1);
        chk("held start table cleared", tbl0, 0);
        chk("held start ones cleared", ones0, 0);
        drain("held start");

        // Reset mid-scan at index 9 abandons it
        scan0(16'h831B, 16'h831B, 5'd7, 1'b1, 4'd0);
        wait_idx0(4'd9);
        rst_n = 1'b0;
        void'(q0.pop_back());
        @(negedge clk);
        chk("midrst i_out", i_out0, 0);
        chk("midrst table", tbl0, 0);
        chk("midrst ones", ones0, 0);
        chk("midrst busy", busy0, 0);
        chk("midrst done", done0, 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        scan0(16'h831B, 16'h831B, 5'd7, 1'b1, 4'd0);
        drain("after reset");

`ifdef TT_SCAN_CHECK_EN
        // Function corrupted at index 3
        scan0(16'h831B ^ 16'h0008, 16'h8313, 5'd6, 1'b0, 4'd3);
        drain("check mismatch");
        repeat (3) @(negedge clk);
        chk("match held", match0, 0);
        chk("first_bad held", fb0, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
